// File: rtl/sweep_sched_pkg.sv
// Shared widths, FSM encoding and config helpers for the LO sweep sequencer.
package sweep_sched_pkg;

  localparam int FTW_W     = 32;
  localparam int NPTS_W    = 10;
  localparam int MAG_W     = 20;
  localparam int PH_W      = 21;
  localparam int NCH       = 4;
  localparam int AVG_MAX   = 7;
  localparam int MAG_ACC_W = MAG_W + AVG_MAX;
  localparam int PH_ACC_W  = PH_W + AVG_MAX;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic [2:0] clamp_avg(input logic [2:0] a);
    if (a > 3'(AVG_MAX)) begin
      return 3'(AVG_MAX);
    end else begin
      return a;
    end
  endfunction

endpackage

// File: rtl/sweep_sched_phase_wrap_acc.sv
// Per-channel phase averager: averages offsets from the first phase so a +/-pi straddle
// does not cancel out.
module sweep_sched_phase_wrap_acc
  import sweep_sched_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic            first,
  input  logic [2:0]      avg,
  input  logic [PH_W-1:0] ph_in,
  output logic [PH_W-1:0] ph_res
);

  logic [PH_W-1:0]            ph0_q, ph0_d;
  logic signed [PH_ACC_W-1:0] sum_q, sum_d;
  logic [PH_W-1:0]            diff_s;
  logic [PH_W-1:0]            base_s;
  logic signed [PH_ACC_W-1:0] sum_nxt_s;
  logic signed [PH_ACC_W-1:0] sum_shr_s;

  // Wrapped difference to the reference phase, running sum and the averaged result
  always_comb begin
    base_s    = first ? ph_in : ph0_q;
    diff_s    = first ? {PH_W{1'b0}} : PH_W'(ph_in - ph0_q);
    sum_nxt_s = (first ? {PH_ACC_W{1'b0}} : sum_q) + {{AVG_MAX{diff_s[PH_W-1]}}, diff_s};
    sum_shr_s = sum_nxt_s >>> avg;
    ph_res    = PH_W'({{AVG_MAX{1'b0}}, base_s} + sum_shr_s);
    if (en) begin
      sum_d = sum_nxt_s;
      ph0_d = base_s;
    end else begin
      sum_d = sum_q;
      ph0_d = ph0_q;
    end
  end

  // Reference phase and sum registers; clr is the abort path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph0_q <= {PH_W{1'b0}};
      sum_q <= {PH_ACC_W{1'b0}};
    end else if (clr) begin
      ph0_q <= {PH_W{1'b0}};
      sum_q <= {PH_ACC_W{1'b0}};
    end else begin
      ph0_q <= ph0_d;
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/sweep_sched.sv
// LO sweep sequencer: steps the DDS word, discards settling frames, averages 2^k frames
// per point and emits one result per point on a valid/ready handshake.
module sweep_sched
  import sweep_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [FTW_W-1:0]      ftw_start,
  input  logic [FTW_W-1:0]      ftw_step,
  input  logic [NPTS_W-1:0]     n_points,
  input  logic [7:0]            settle_frms,
  input  logic [2:0]            avg_log2,
  output logic [FTW_W-1:0]      dds_ftw,
  input  logic                  frm_stb,
  input  logic [NCH*MAG_W-1:0]  mag_in,
  input  logic [NCH*PH_W-1:0]   ph_in,
  output logic                  busy,
  output logic                  done,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [NPTS_W-1:0]     o_idx,
  output logic [FTW_W-1:0]      o_ftw,
  output logic [NCH*MAG_W-1:0]  o_mag,
  output logic [NCH*PH_W-1:0]   o_ph
);

  state_t                 state_q, state_d;
  logic [NPTS_W-1:0]      n_pts_q, n_pts_d, idx_q, idx_d, o_idx_q, o_idx_d;
  logic [7:0]             settle_q, settle_d, cnt_q, cnt_d;
  logic [2:0]             avg_q, avg_d;
  logic [FTW_W-1:0]       dds_ftw_q, dds_ftw_d, o_ftw_q, o_ftw_d;
  logic [MAG_ACC_W-1:0]   mag_acc_q [NCH];
  logic [MAG_ACC_W-1:0]   mag_acc_d [NCH];
  logic [MAG_ACC_W-1:0]   mag_sum_s [NCH];
  logic [NCH*MAG_W-1:0]   o_mag_q, o_mag_d;
  logic [NCH*PH_W-1:0]    o_ph_q, o_ph_d, ph_res_s;
  logic                   o_valid_q, o_valid_d, busy_q, busy_d, done_q, done_d;
  logic                   first_s, last_s, ph_en_s;
  logic [7:0]             avg_len_s;

  // Frame position within the averaging window and per-channel magnitude sums
  always_comb begin
    avg_len_s = 8'd1 << avg_q;
    first_s   = (cnt_q == 8'd0);
    last_s    = (cnt_q == avg_len_s - 8'd1);
    ph_en_s   = frm_stb && (state_q == ST_ACCUM) && !abort;
    for (int c = 0; c < NCH; c++) begin
      mag_sum_s[c] = (first_s ? {MAG_ACC_W{1'b0}} : mag_acc_q[c])
                   + MAG_ACC_W'(mag_in[c*MAG_W +: MAG_W]);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ph
    sweep_sched_phase_wrap_acc u_ph (
      .clk    (clk),
      .reset  (reset),
      .clr    (abort),
      .en     (ph_en_s),
      .first  (first_s),
      .avg    (avg_q),
      .ph_in  (ph_in[g*PH_W +: PH_W]),
      .ph_res (ph_res_s[g*PH_W +: PH_W])
    );
  end

  // Next-state and datapath; abort clears everything except the LO word
  always_comb begin
    state_d   = state_q;
    n_pts_d   = n_pts_q;
    settle_d  = settle_q;
    avg_d     = avg_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dds_ftw_d = dds_ftw_q;
    o_idx_d   = o_idx_q;
    o_ftw_d   = o_ftw_q;
    o_mag_d   = o_mag_q;
    o_ph_d    = o_ph_q;
    o_valid_d = o_valid_q;
    done_d    = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      mag_acc_d[c] = mag_acc_q[c];
    end
    if (abort) begin
      state_d   = ST_IDLE;
      n_pts_d   = {NPTS_W{1'b0}};
      settle_d  = 8'd0;
      avg_d     = 3'd0;
      idx_d     = {NPTS_W{1'b0}};
      cnt_d     = 8'd0;
      o_idx_d   = {NPTS_W{1'b0}};
      o_ftw_d   = {FTW_W{1'b0}};
      o_mag_d   = {(NCH*MAG_W){1'b0}};
      o_ph_d    = {(NCH*PH_W){1'b0}};
      o_valid_d = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        mag_acc_d[c] = {MAG_ACC_W{1'b0}};
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_pts_d   = n_points;
            settle_d  = settle_frms;
            avg_d     = clamp_avg(avg_log2);
            dds_ftw_d = ftw_start;
            idx_d     = {NPTS_W{1'b0}};
            cnt_d     = 8'd0;
            if (n_points == {NPTS_W{1'b0}}) begin
              state_d = ST_DONE;
            end else if (settle_frms == 8'd0) begin
              state_d = ST_ACCUM;
            end else begin
              state_d = ST_SETTLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (frm_stb) begin
            if (cnt_q == settle_q - 8'd1) begin
              cnt_d   = 8'd0;
              state_d = ST_ACCUM;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_ACCUM: begin
          if (frm_stb) begin
            for (int c = 0; c < NCH; c++) begin
              mag_acc_d[c] = mag_sum_s[c];
            end
            if (last_s) begin
              for (int c = 0; c < NCH; c++) begin
                o_mag_d[c*MAG_W +: MAG_W] = MAG_W'(mag_sum_s[c] >> avg_q);
              end
              o_ph_d    = ph_res_s;
              o_idx_d   = idx_q;
              o_ftw_d   = dds_ftw_q;
              o_valid_d = 1'b1;
              cnt_d     = 8'd0;
              state_d   = ST_EMIT;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_EMIT: begin
          if (o_ready) begin
            o_valid_d = 1'b0;
            cnt_d     = 8'd0;
            if (idx_q == n_pts_q - NPTS_W'(1)) begin
              state_d = ST_DONE;
            end else begin
              idx_d     = idx_q + NPTS_W'(1);
              dds_ftw_d = dds_ftw_q + ftw_step;
              state_d   = (settle_q == 8'd0) ? ST_ACCUM : ST_SETTLE;
            end
          end else begin
            state_d = ST_EMIT;
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, configuration, accumulator and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      n_pts_q   <= {NPTS_W{1'b0}};
      settle_q  <= 8'd0;
      avg_q     <= 3'd0;
      idx_q     <= {NPTS_W{1'b0}};
      cnt_q     <= 8'd0;
      dds_ftw_q <= {FTW_W{1'b0}};
      o_idx_q   <= {NPTS_W{1'b0}};
      o_ftw_q   <= {FTW_W{1'b0}};
      o_mag_q   <= {(NCH*MAG_W){1'b0}};
      o_ph_q    <= {(NCH*PH_W){1'b0}};
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        mag_acc_q[c] <= {MAG_ACC_W{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      n_pts_q   <= n_pts_d;
      settle_q  <= settle_d;
      avg_q     <= avg_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      dds_ftw_q <= dds_ftw_d;
      o_idx_q   <= o_idx_d;
      o_ftw_q   <= o_ftw_d;
      o_mag_q   <= o_mag_d;
      o_ph_q    <= o_ph_d;
      o_valid_q <= o_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int c = 0; c < NCH; c++) begin
        mag_acc_q[c] <= mag_acc_d[c];
      end
    end
  end

  assign dds_ftw = dds_ftw_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign o_valid = o_valid_q;
  assign o_idx   = o_idx_q;
  assign o_ftw   = o_ftw_q;
  assign o_mag   = o_mag_q;
  assign o_ph    = o_ph_q;

endmodule
